// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes little-endian words into imem port A,
// and holds the core in reset until a frame with a correct checksum has been loaded.
module imem_boot_loader #(
   parameter int unsigned IMEM_AW     = 10,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic               pad_clk,
   input  logic               pad_rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_ena,
   output logic               imem_wea,
   output logic [IMEM_AW-1:0] imem_addra,
   output logic [31:0]        imem_dia,
   output logic               core_rst_n,
   output logic               boot_done,
   output logic               boot_err,
   output logic               busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [16:0] DEPTH = 17'(1) << IMEM_AW;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t             state, state_nxt;
   logic               acc;
   logic               rdy_nxt;
   logic               wr_nxt;
   logic               timed;
   logic               tmo_hit;
   logic               len_bad;
   logic               word_last;
   logic [15:0]        len_in;
   logic [7:0]         len_lo;
   logic [IMEM_AW-1:0] last_idx;
   logic [IMEM_AW-1:0] word_idx;
   logic [1:0]         byte_cnt;
   logic [7:0]         csum;
   logic [23:0]        asm_p0;
   logic [TMO_W-1:0]   tmo_cnt;

   assign acc       = rx_valid && rx_ready;
   assign len_in    = {rx_data, len_lo};
   assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > DEPTH);
   assign timed     = state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
   // timeout fires on the edge that would make the idle count reach TIMEOUT_CYC
   assign tmo_hit   = timed && !acc && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign word_last = (byte_cnt == 2'd3) && (word_idx == last_idx);

   always_comb begin
      state_nxt = state;
      rdy_nxt   = 1'b0;
      wr_nxt    = 1'b0;
      case (state)
         S_IDLE: if (acc && rx_data == SYNC_BYTE) state_nxt = S_LEN0;
         S_LEN0: if (acc) state_nxt = S_LEN1;
                 else if (tmo_hit) state_nxt = S_ERR;
         S_LEN1: if (acc) state_nxt = len_bad ? S_ERR : S_DATA;
                 else if (tmo_hit) state_nxt = S_ERR;
         S_DATA: if (acc) begin
                    if (word_last) state_nxt = S_CSUM;
                 end else if (tmo_hit) state_nxt = S_ERR;
         S_CSUM: if (acc) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
                 else if (tmo_hit) state_nxt = S_ERR;
         S_DONE: state_nxt = S_DONE;
         S_ERR:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      wr_nxt  = (state == S_DATA) && acc && (byte_cnt == 2'd3);
      rdy_nxt = (state_nxt != S_DONE) && (state_nxt != S_ERR);
   end

   always_ff @(posedge pad_clk) begin
      if (!pad_rst_n) begin
         state      <= S_IDLE;
         rx_ready   <= 1'b0;
         imem_ena   <= 1'b0;
         imem_wea   <= 1'b0;
         imem_addra <= '0;
         imem_dia   <= '0;
         core_rst_n <= 1'b0;
         boot_done  <= 1'b0;
         boot_err   <= 1'b0;
         busy       <= 1'b0;
         tmo_cnt    <= '0;
         len_lo     <= '0;
         last_idx   <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         csum       <= '0;
         asm_p0     <= '0;
      end else begin
         state    <= state_nxt;
         rx_ready <= rdy_nxt;
         imem_ena <= wr_nxt;
         imem_wea <= wr_nxt;
         tmo_cnt  <= (timed && !acc) ? tmo_cnt + TMO_W'(1) : '0;

         if (acc && state == S_IDLE && rx_data == SYNC_BYTE) begin
            boot_err <= 1'b0;
            busy     <= 1'b1;
         end
         if (state_nxt == S_ERR) begin
            boot_err <= 1'b1;
            busy     <= 1'b0;
         end
         if (state_nxt == S_DONE) begin
            boot_done  <= 1'b1;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
         end

         if (acc) begin
            case (state)
               S_LEN0: len_lo <= rx_data;
               S_LEN1: begin
                  last_idx <= IMEM_AW'(len_in - 16'd1);
                  word_idx <= '0;
                  byte_cnt <= '0;
                  csum     <= '0;
               end
               // _p0 holds the first three bytes; the fourth completes the word on the write stage
               S_DATA: begin
                  csum     <= csum + rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_p0   <= {rx_data, asm_p0[23:8]};
                  if (byte_cnt == 2'd3) begin
                     imem_addra <= word_idx;
                     imem_dia   <= {rx_data, asm_p0};
                     word_idx   <= word_idx + IMEM_AW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_boot_loader;

   localparam int         AW   = 4;
   localparam int         TMO  = 100;
   localparam logic [7:0] SYNC = 8'hA5;

   logic          pad_clk = 1'b0;
   logic          pad_rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_ena;
   logic          imem_wea;
   logic [AW-1:0] imem_addra;
   logic [31:0]   imem_dia;
   logic          core_rst_n;
   logic          boot_done;
   logic          boot_err;
   logic          busy;

   imem_boot_loader #(.IMEM_AW(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)) dut (
      .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_ena(imem_ena), .imem_wea(imem_wea), .imem_addra(imem_addra),
      .imem_dia(imem_dia), .core_rst_n(core_rst_n), .boot_done(boot_done),
      .boot_err(boot_err), .busy(busy)
   );

   always #5 pad_clk = ~pad_clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mem [0:(1<<AW)-1];
   int          wr_cnt = 0;
   bit          cmp_en = 0;
   logic [7:0]  txq [$];

   // reference model: position within the frame decides the meaning of each accepted byte
   bit          m_rdy = 0, m_ena = 0, m_done = 0, m_err = 0, m_busy = 0;
   logic [AW-1:0] m_addr = '0;
   logic [31:0] m_dia = '0;
   bit          in_frame = 0, err_cyc = 0, fail, acc;
   int          pos, n, idle, k;
   logic [7:0]  len_lo_m, sum;
   logic [31:0] word;

   initial forever begin
      @(posedge pad_clk);
      acc   = rx_valid && m_rdy;
      m_ena = 0;
      if (!pad_rst_n) begin
         m_rdy = 0; m_done = 0; m_err = 0; m_busy = 0;
         m_addr = '0; m_dia = '0; in_frame = 0; err_cyc = 0;
      end else if (m_done) begin
         m_rdy = 0;
      end else if (err_cyc) begin
         err_cyc = 0;
         m_rdy   = 1;
      end else if (!in_frame) begin
         if (acc && rx_data == SYNC) begin
            in_frame = 1; pos = 0; idle = 0; m_err = 0; m_busy = 1;
         end
         m_rdy = 1;
      end else begin
         fail = 0;
         if (acc) begin
            idle = 0;
            if (pos == 0) len_lo_m = rx_data;
            else if (pos == 1) begin
               n    = int'({rx_data, len_lo_m});
               sum  = 8'h00;
               word = 32'h0;
               fail = (n == 0) || (n > (1 << AW));
            end else if (pos < 2 + 4*n) begin
               k = pos - 2;
               sum = sum + rx_data;
               word[8*(k%4) +: 8] = rx_data;
               if (k % 4 == 3) begin
                  m_ena  = 1;
                  m_addr = AW'(k/4);
                  m_dia  = word;
               end
            end else begin
               if (rx_data == sum) begin
                  m_done = 1; m_busy = 0; in_frame = 0;
               end else fail = 1;
            end
            pos++;
         end else begin
            idle++;
            if (idle == TMO) fail = 1;
         end
         if (fail) begin
            in_frame = 0; m_err = 1; m_busy = 0; err_cyc = 1;
         end
         m_rdy = !m_done && !err_cyc;
      end
   end

   // per-cycle comparison against the model, plus a shadow of imem port A
   initial forever begin
      logic [42:0] act, exp;
      @(negedge pad_clk);
      if (imem_ena === 1'b1 && imem_wea === 1'b1) begin
         mem[imem_addra] = imem_dia;
         wr_cnt++;
      end
      if (cmp_en) begin
         act = {rx_ready, imem_ena, imem_wea, imem_addra, imem_dia, core_rst_n, boot_done, boot_err, busy};
         exp = {m_rdy, m_ena, m_ena, m_addr, m_dia, m_done, m_done, m_err, m_busy};
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got rdy,ena,wea,addr,dia,crst,done,err,busy=%h required %h",
                     $time, act, exp);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int w = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && w < 20) begin
         @(negedge pad_clk);
         w++;
      end
      if (rx_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL rx_ready_wait: got %b required 1", rx_ready);
      end
      @(negedge pad_clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_q();
      foreach (txq[i]) send(txq[i]);
   endtask

   task automatic do_reset();
      pad_rst_n = 1'b0;
      repeat (2) @(negedge pad_clk);
      pad_rst_n = 1'b1;
      @(negedge pad_clk);
   endtask

   initial begin
      int         w0;
      logic [7:0] s;
      logic [7:0] b;
      pad_rst_n = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      repeat (3) @(negedge pad_clk);
      cmp_en = 1;
      chk("reset_ready", 32'(rx_ready), 32'd0);
      chk("reset_flags", 32'({core_rst_n, boot_done, boot_err, busy, imem_ena, imem_wea}), 32'd0);
      chk("reset_port", 32'(imem_dia) | 32'(imem_addra), 32'd0);
      pad_rst_n = 1'b1;
      @(negedge pad_clk);
      chk("idle_ready", 32'(rx_ready), 32'd1);

      // nominal two-word load
      w0 = wr_cnt;
      txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
      send_q();
      chk("nom_done", 32'({boot_done, core_rst_n, rx_ready}), 32'b110);
      @(negedge pad_clk);
      chk("nom_mem0", mem[0], 32'h00100513);
      chk("nom_mem1", mem[1], 32'h00200593);
      chk("nom_wrcnt", 32'(wr_cnt - w0), 32'd2);

      // bad checksum, then a good frame
      do_reset();
      txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE1};
      send_q();
      chk("bad_csum_err", 32'({boot_err, core_rst_n, boot_done}), 32'b100);
      send(SYNC);
      chk("sync_clears_err", 32'({boot_err, busy}), 32'b01);
      txq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
      send_q();
      chk("retry_done", 32'({boot_done, core_rst_n, boot_err}), 32'b110);

      // illegal lengths
      do_reset();
      w0 = wr_cnt;
      txq = '{8'hA5, 8'h00, 8'h00};
      send_q();
      chk("len0_err", 32'(boot_err), 32'd1);
      txq = '{8'hA5, 8'h11, 8'h00};
      send_q();
      chk("len17_err", 32'(boot_err), 32'd1);
      chk("len_no_write", 32'(wr_cnt - w0), 32'd0);

      // garbage before sync, sync value inside payload
      txq = '{8'h00, 8'hFF, 8'h5A};
      send_q();
      chk("garbage_idle", 32'(busy), 32'd0);
      txq = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h0B};
      send_q();
      chk("garbage_done", 32'({boot_done, boot_err}), 32'b10);
      @(negedge pad_clk);
      chk("garbage_mem0", mem[0], 32'h332211A5);

      // timeout exactly TMO cycles after the last accepted byte
      do_reset();
      w0 = wr_cnt;
      txq = '{8'hA5, 8'h01, 8'h00, 8'h11};
      send_q();
      repeat (TMO - 1) @(negedge pad_clk);
      chk("tmo_before", 32'({boot_err, busy}), 32'b01);
      @(negedge pad_clk);
      chk("tmo_at", 32'({boot_err, busy, core_rst_n}), 32'b100);
      chk("tmo_no_write", 32'(wr_cnt - w0), 32'd0);

      // full memory, last address 2^AW-1
      do_reset();
      w0 = wr_cnt;
      txq = '{8'hA5, 8'h10, 8'h00};
      send_q();
      s = 8'h00;
      for (int i = 0; i < 64; i++) begin
         b = 8'(i*37 + 1);
         s = s + b;
         send(b);
      end
      send(s);
      chk("full_done", 32'(boot_done), 32'd1);
      @(negedge pad_clk);
      chk("full_mem0", mem[0], 32'h704B2601);
      chk("full_mem15", mem[15], 32'h1CF7D2AD);
      chk("full_wrcnt", 32'(wr_cnt - w0), 32'd16);

      // reset in the middle of a frame
      do_reset();
      w0 = wr_cnt;
      txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
      send_q();
      pad_rst_n = 1'b0;
      rx_valid  = 1'b1;
      rx_data   = SYNC;
      @(negedge pad_clk);
      chk("midrst_flags", 32'({rx_ready, busy, boot_err, boot_done, core_rst_n}), 32'd0);
      chk("midrst_port", 32'(imem_dia) | 32'(imem_addra), 32'd0);
      chk("midrst_mem0", mem[0], 32'h00100513);
      chk("midrst_wrcnt", 32'(wr_cnt - w0), 32'd1);
      pad_rst_n = 1'b1;
      rx_valid  = 1'b0;
      @(negedge pad_clk);
      txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
      send_q();
      chk("midrst_reload", 32'({boot_done, core_rst_n}), 32'b11);
      @(negedge pad_clk);
      chk("midrst_mem1", mem[1], 32'h00200593);

      repeat (2) @(negedge pad_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
